// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle accumulator controller:
// FSM states, opcode values and ALU operation selects.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OP_RD  = 3'd3,
        ST_OP_WR  = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [2:0] OPC_NOP = 3'b000;
    localparam logic [2:0] OPC_LDA = 3'b001;
    localparam logic [2:0] OPC_STA = 3'b010;
    localparam logic [2:0] OPC_ADD = 3'b011;
    localparam logic [2:0] OPC_SUB = 3'b100;
    localparam logic [2:0] OPC_JMP = 3'b101;
    localparam logic [2:0] OPC_BRZ = 3'b110;
    localparam logic [2:0] OPC_HLT = 3'b111;

    localparam logic [1:0] ALU_PASS_B = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_SUB    = 2'b10;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier for the controller.
// Config macro: MC_CTRL_BRZ_EN enables BRZ; otherwise opcode 110 decodes as NOP.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W    = 3,
    parameter int ALU_OP_W = 2
) (
    input  logic [OPC_W-1:0]    opcode_i,
    output logic                is_mem_rd_o,
    output logic                is_mem_wr_o,
    output logic                is_jump_o,
    output logic                is_branch_o,
    output logic                is_halt_o,
    output logic [ALU_OP_W-1:0] alu_op_o
);

    always_comb begin
        is_mem_rd_o = 1'b0;
        is_mem_wr_o = 1'b0;
        is_jump_o   = 1'b0;
        is_branch_o = 1'b0;
        is_halt_o   = 1'b0;
        alu_op_o    = ALU_OP_W'(ALU_PASS_B);
        case (opcode_i)
            OPC_LDA: is_mem_rd_o = 1'b1;
            OPC_ADD: begin
                is_mem_rd_o = 1'b1;
                alu_op_o    = ALU_OP_W'(ALU_ADD);
            end
            OPC_SUB: begin
                is_mem_rd_o = 1'b1;
                alu_op_o    = ALU_OP_W'(ALU_SUB);
            end
            OPC_STA: is_mem_wr_o = 1'b1;
            OPC_JMP: is_jump_o   = 1'b1;
`ifdef MC_CTRL_BRZ_EN
            OPC_BRZ: is_branch_o = 1'b1;
`endif
            OPC_HLT: is_halt_o   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_fsm_controller.sv
// Multi-cycle fetch/decode/operand/execute controller for the 8-bit accumulator datapath.
// Config macro: MC_CTRL_BRZ_EN (handled inside mc_opcode_decode).
module mc_fsm_controller
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W    = 3,
    parameter int ALU_OP_W = 2
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [OPC_W-1:0]    ir_opcode_i,
    input  logic                zero_flag_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                addr_sel_o,
    output logic                ir_load_o,
    output logic                pc_inc_o,
    output logic                pc_load_o,
    output logic                acc_load_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                busy_o,
    output logic                halted_o
);

    state_e state_q, state_d;

    logic                is_mem_rd, is_mem_wr, is_jump, is_branch, is_halt;
    logic [ALU_OP_W-1:0] dec_alu_op;

    mc_opcode_decode #(
        .OPC_W    (OPC_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_dec (
        .opcode_i    (ir_opcode_i),
        .is_mem_rd_o (is_mem_rd),
        .is_mem_wr_o (is_mem_wr),
        .is_jump_o   (is_jump),
        .is_branch_o (is_branch),
        .is_halt_o   (is_halt),
        .alu_op_o    (dec_alu_op)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        addr_sel_o = 1'b0;
        ir_load_o  = 1'b0;
        pc_inc_o   = 1'b0;
        pc_load_o  = 1'b0;
        acc_load_o = 1'b0;
        alu_op_o   = '0;
        busy_o     = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted_o   = (state_q == ST_HALT);
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_load_o = 1'b1;
                    pc_inc_o  = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch gating is folded into is_branch, so this is plain logic.
                pc_load_o = is_jump | (is_branch & zero_flag_i);
                if (is_halt)        state_d = ST_HALT;
                else if (is_mem_rd) state_d = ST_OP_RD;
                else if (is_mem_wr) state_d = ST_OP_WR;
                else                state_d = ST_FETCH;
            end
            ST_OP_RD: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                alu_op_o   = dec_alu_op;
                if (mem_ready_i) begin
                    acc_load_o = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_OP_WR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                addr_sel_o = 1'b1;
                if (mem_ready_i) state_d = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
        // Reset squashes every output immediately, dropping any in-flight access.
        if (reset_i) begin
            mem_req_o  = 1'b0;
            mem_we_o   = 1'b0;
            addr_sel_o = 1'b0;
            ir_load_o  = 1'b0;
            pc_inc_o   = 1'b0;
            pc_load_o  = 1'b0;
            acc_load_o = 1'b0;
            alu_op_o   = '0;
            busy_o     = 1'b0;
            halted_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_fsm_controller.sv
// Directed cycle-by-cycle bench for mc_fsm_controller: each row drives inputs
// for one cycle and gives the hand-derived output vector for that cycle.
module tb_mc_fsm_controller;
    import mc_ctrl_pkg::*;

    logic       clock, reset, start, zero_flag, mem_ready;
    logic [2:0] ir_opcode;
    logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load, busy, halted;
    logic [1:0] alu_op;

    int n_chk  = 0;
    int n_fail = 0;

    mc_fsm_controller #(.OPC_W(3), .ALU_OP_W(2)) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .start_i     (start),
        .ir_opcode_i (ir_opcode),
        .zero_flag_i (zero_flag),
        .mem_ready_i (mem_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .addr_sel_o  (addr_sel),
        .ir_load_o   (ir_load),
        .pc_inc_o    (pc_inc),
        .pc_load_o   (pc_load),
        .acc_load_o  (acc_load),
        .alu_op_o    (alu_op),
        .busy_o      (busy),
        .halted_o    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bit order: req we asel irl pci pcl accl alu[1:0] busy halted
    logic [10:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op, busy, halted};

    localparam logic [10:0] E_IDLE = 11'b0_0_0_0_0_0_0_00_0_0;
    localparam logic [10:0] E_FN   = 11'b1_0_0_0_0_0_0_00_1_0;
    localparam logic [10:0] E_FR   = 11'b1_0_0_1_1_0_0_00_1_0;
    localparam logic [10:0] E_DEC  = 11'b0_0_0_0_0_0_0_00_1_0;
    localparam logic [10:0] E_JMP  = 11'b0_0_0_0_0_1_0_00_1_0;
    localparam logic [10:0] E_RDN  = 11'b1_0_1_0_0_0_0_00_1_0;
    localparam logic [10:0] E_LDA  = 11'b1_0_1_0_0_0_1_00_1_0;
    localparam logic [10:0] E_ADD  = 11'b1_0_1_0_0_0_1_01_1_0;
    localparam logic [10:0] E_WR   = 11'b1_1_1_0_0_0_0_00_1_0;
    localparam logic [10:0] E_HALT = 11'b0_0_0_0_0_0_0_00_0_1;
`ifdef MC_CTRL_BRZ_EN
    localparam logic [10:0] E_BRZ1 = E_JMP;
`else
    localparam logic [10:0] E_BRZ1 = E_DEC;
`endif

    typedef struct {
        logic        rst, st, rdy, zf;
        logic [2:0]  opc;
        logic [10:0] exp;
    } row_t;
    row_t rows[$];

    task automatic add(input logic rst, st, rdy, zf, input logic [2:0] opc, input logic [10:0] exp);
        rows.push_back('{rst, st, rdy, zf, opc, exp});
    endtask

    task automatic test_reset();
        rows.delete();
        add(1, 0, 0, 0, OPC_NOP, E_IDLE);
        add(1, 1, 1, 1, OPC_HLT, E_IDLE);
        add(0, 1, 0, 0, OPC_NOP, E_IDLE);
        add(0, 0, 0, 0, OPC_NOP, E_FN);
        for (int i = 0; i < rows.size(); i++) begin
            reset = rows[i].rst; start = rows[i].st; mem_ready = rows[i].rdy;
            zero_flag = rows[i].zf; ir_opcode = rows[i].opc; #1;
            n_chk++;
            if (obs !== rows[i].exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, rows[i].exp);
            end
            @(posedge clock); #1;
        end
    endtask

    // LDA 5; ADD 6; STA 7; HLT with zero-wait memory: 11 cycles to HALT.
    task automatic test_program();
        rows.delete();
        add(1, 0, 1, 0, OPC_NOP, E_IDLE);
        add(0, 1, 1, 0, OPC_NOP, E_IDLE);
        add(0, 0, 1, 0, OPC_NOP, E_FR);
        add(0, 0, 1, 0, OPC_LDA, E_DEC);
        add(0, 0, 1, 0, OPC_LDA, E_LDA);
        add(0, 0, 1, 0, OPC_LDA, E_FR);
        add(0, 0, 1, 0, OPC_ADD, E_DEC);
        add(0, 0, 1, 0, OPC_ADD, E_ADD);
        add(0, 0, 1, 0, OPC_ADD, E_FR);
        add(0, 0, 1, 0, OPC_STA, E_DEC);
        add(0, 0, 1, 0, OPC_STA, E_WR);
        add(0, 0, 1, 0, OPC_STA, E_FR);
        add(0, 0, 1, 0, OPC_HLT, E_DEC);
        add(0, 1, 1, 0, OPC_HLT, E_HALT);
        add(0, 1, 1, 1, OPC_LDA, E_HALT);
        add(0, 0, 0, 0, OPC_NOP, E_HALT);
        for (int i = 0; i < rows.size(); i++) begin
            reset = rows[i].rst; start = rows[i].st; mem_ready = rows[i].rdy;
            zero_flag = rows[i].zf; ir_opcode = rows[i].opc; #1;
            n_chk++;
            if (obs !== rows[i].exp) begin
                n_fail++;
                $display("FAIL program[%0d]: got %b expected %b", i, obs, rows[i].exp);
            end
            @(posedge clock); #1;
        end
    endtask

    // Three wait cycles in FETCH and in OP_RD: LDA spans 9 cycles.
    task automatic test_wait_states();
        rows.delete();
        add(1, 0, 0, 0, OPC_NOP, E_IDLE);
        add(0, 1, 0, 0, OPC_NOP, E_IDLE);
        add(0, 0, 0, 0, OPC_NOP, E_FN);
        add(0, 0, 0, 0, OPC_NOP, E_FN);
        add(0, 1, 0, 0, OPC_NOP, E_FN);
        add(0, 0, 1, 0, OPC_NOP, E_FR);
        add(0, 0, 1, 0, OPC_LDA, E_DEC);
        add(0, 0, 0, 0, OPC_LDA, E_RDN);
        add(0, 1, 0, 0, OPC_LDA, E_RDN);
        add(0, 0, 0, 0, OPC_LDA, E_RDN);
        add(0, 0, 1, 0, OPC_LDA, E_LDA);
        add(0, 1, 0, 0, OPC_LDA, E_FN);
        for (int i = 0; i < rows.size(); i++) begin
            reset = rows[i].rst; start = rows[i].st; mem_ready = rows[i].rdy;
            zero_flag = rows[i].zf; ir_opcode = rows[i].opc; #1;
            n_chk++;
            if (obs !== rows[i].exp) begin
                n_fail++;
                $display("FAIL wait[%0d]: got %b expected %b", i, obs, rows[i].exp);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_branch();
        rows.delete();
        add(1, 0, 1, 0, OPC_NOP, E_IDLE);
        add(0, 1, 1, 0, OPC_NOP, E_IDLE);
        add(0, 0, 1, 0, OPC_NOP, E_FR);
        add(0, 0, 1, 0, OPC_JMP, E_JMP);
        add(0, 0, 1, 0, OPC_JMP, E_FR);
        add(0, 0, 1, 1, OPC_BRZ, E_BRZ1);
        add(0, 0, 1, 1, OPC_BRZ, E_FR);
        add(0, 0, 1, 0, OPC_BRZ, E_DEC);
        add(0, 0, 1, 0, OPC_BRZ, E_FR);
        add(0, 0, 1, 1, OPC_NOP, E_DEC);
        add(0, 0, 1, 1, OPC_NOP, E_FR);
        for (int i = 0; i < rows.size(); i++) begin
            reset = rows[i].rst; start = rows[i].st; mem_ready = rows[i].rdy;
            zero_flag = rows[i].zf; ir_opcode = rows[i].opc; #1;
            n_chk++;
            if (obs !== rows[i].exp) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %b expected %b", i, obs, rows[i].exp);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid();
        rows.delete();
        add(1, 0, 0, 0, OPC_NOP, E_IDLE);
        add(0, 1, 0, 0, OPC_NOP, E_IDLE);
        add(0, 0, 1, 0, OPC_NOP, E_FR);
        add(0, 0, 1, 0, OPC_STA, E_DEC);
        add(0, 0, 0, 0, OPC_STA, E_WR);
        add(1, 0, 0, 0, OPC_STA, E_IDLE);
        add(0, 0, 1, 0, OPC_STA, E_IDLE);
        add(0, 1, 0, 0, OPC_STA, E_IDLE);
        add(0, 0, 0, 0, OPC_STA, E_FN);
        for (int i = 0; i < rows.size(); i++) begin
            reset = rows[i].rst; start = rows[i].st; mem_ready = rows[i].rdy;
            zero_flag = rows[i].zf; ir_opcode = rows[i].opc; #1;
            n_chk++;
            if (obs !== rows[i].exp) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %b expected %b", i, obs, rows[i].exp);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_spurious();
        rows.delete();
        add(1, 0, 0, 0, OPC_NOP, E_IDLE);
        add(0, 0, 1, 0, OPC_NOP, E_IDLE);
        add(0, 0, 1, 1, OPC_HLT, E_IDLE);
        add(0, 1, 0, 0, OPC_NOP, E_IDLE);
        add(0, 1, 1, 0, OPC_NOP, E_FR);
        add(0, 1, 1, 1, OPC_NOP, E_DEC);
        add(0, 1, 0, 0, OPC_NOP, E_FN);
        add(0, 0, 1, 0, OPC_SUB, E_FR);
        add(0, 1, 1, 0, OPC_HLT, E_DEC);
        add(0, 0, 1, 0, OPC_HLT, E_HALT);
        for (int i = 0; i < rows.size(); i++) begin
            reset = rows[i].rst; start = rows[i].st; mem_ready = rows[i].rdy;
            zero_flag = rows[i].zf; ir_opcode = rows[i].opc; #1;
            n_chk++;
            if (obs !== rows[i].exp) begin
                n_fail++;
                $display("FAIL spurious[%0d]: got %b expected %b", i, obs, rows[i].exp);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; zero_flag = 1'b0; ir_opcode = OPC_NOP;
        test_reset();
        test_program();
        test_wait_states();
        test_branch();
        test_reset_mid();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/mc_fsm_controller.md
# mc_fsm_controller

Multi-cycle control FSM that sequences the 8-bit accumulator datapath: the PC, IR and ACC registers, the ALU and a single shared memory port. Each instruction runs as fetch → decode → optional memory operand → execute. The block drives register load enables, ALU op and address-mux select, and waits on a memory ready handshake. It sits beside the datapath in the processor top level and owns no data registers itself.

## Interface
Parameters:
- OPC_W, 3, opcode width (IR[7:5])
- ALU_OP_W, 2, ALU operation select width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level/pulse; begins execution from IDLE
- ir_opcode  in  OPC_W  opcode field from the IR register output
- zero_flag  in  1  ACC == 0 from datapath
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe (ACC → mem), valid only with mem_req
- addr_sel  out  1  0 = PC drives address, 1 = IR[4:0] drives address
- ir_load  out  1  IR ← mem read data
- pc_inc  out  1  PC ← PC + 1 (mod 32)
- pc_load  out  1  PC ← IR[4:0]
- acc_load  out  1  ACC ← ALU result
- alu_op  out  ALU_OP_W  00 PASS_B, 01 ADD, 10 SUB, 11 reserved
- busy  out  1  state not IDLE and not HALT
- halted  out  1  state == HALT

## Operation
- Opcodes: 000 NOP, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 JMP, 110 BRZ, 111 HLT.
- States: IDLE, FETCH, DECODE, OP_RD, OP_WR, HALT.
- IDLE: all outputs 0. start=1 → FETCH. start is ignored in every other state.
- FETCH: mem_req=1, addr_sel=0. If mem_ready=1: ir_load=1, pc_inc=1, next DECODE. Otherwise hold.
- DECODE (one cycle):
  - NOP → FETCH.
  - LDA/ADD/SUB → OP_RD.
  - STA → OP_WR.
  - JMP: pc_load=1 → FETCH.
  - BRZ: pc_load=zero_flag → FETCH.
  - HLT → HALT.
- OP_RD: mem_req=1, addr_sel=1, alu_op = PASS_B (LDA), ADD or SUB. If mem_ready=1: acc_load=1, next FETCH.
- OP_WR: mem_req=1, mem_we=1, addr_sel=1. If mem_ready=1, next FETCH.
- HALT: absorbing; only reset exits. halted=1.
- Outputs are combinational from state plus mem_ready/zero_flag (Mealy on the ready-qualified strobes). Load strobes assert for exactly one cycle per instruction.
- mem_ready while mem_req=0 is ignored.
- PC wrap (31 → 0) is a datapath behaviour; the controller does not detect it.

## Timing
- Reset: when reset=1 at a rising edge, next state is IDLE. While reset=1, every output is forced to 0 combinationally. This applies from any state, including mid-request; the aborted memory access is dropped with no strobe.
- Zero-wait memory (mem_ready tied 1), cycles per instruction:
  - NOP/JMP/BRZ/HLT: 2
  - LDA/ADD/SUB/STA: 3
- Each wait cycle on mem_ready adds one cycle in FETCH, OP_RD or OP_WR.
- mem_req and mem_we stay stable and asserted until the cycle mem_ready=1.
- start=1 in IDLE: FETCH begins on the following cycle.

## Configuration
- MC_CTRL_BRZ_EN defined: opcode 110 executes BRZ as described above.
- MC_CTRL_BRZ_EN undefined: opcode 110 decodes as NOP. pc_load is never asserted for it, and the zero_flag input is unused.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state encoding (6 states, 3-bit)
  - opcode constants OPC_NOP..OPC_HLT
  - ALU op constants ALU_PASS_B, ALU_ADD, ALU_SUB
- Sub-module mc_opcode_decode is combinational and is instantiated once. It maps ir_opcode to the class flags is_mem_rd, is_mem_wr, is_jump, is_branch, is_halt and to alu_op. The BRZ_EN gating lives here.
- Controller RTL: state register, next-state logic and output logic.

## Test plan
- Reset/start: reset 2 cycles then start=1 → all outputs 0 during reset; FETCH, mem_req=1, addr_sel=0 on the cycle after start.
- Program run with zero-wait memory: LDA 5 (mem[5]=3), ADD 6 (mem[6]=4), STA 7, HLT → acc_load pulses with alu_op 00 then 01; mem_we=1 with addr_sel=1 once; halted=1 after 11 cycles; start ignored afterwards.
- Wait states: mem_ready low for 3 cycles during FETCH and OP_RD → mem_req held steady; ir_load/acc_load fire only on the ready cycle; LDA takes 9 cycles.
- Branch: JMP 20 → pc_load=1 in DECODE. BRZ with zero_flag=1 → pc_load=1; with zero_flag=0 → pc_load=0. Without MC_CTRL_BRZ_EN, opcode 110 → pc_load=0 and 2-cycle NOP.
- Reset mid-operation: reset=1 in OP_WR while mem_ready=0 → mem_req and mem_we drop immediately; IDLE next cycle; no write strobe.
- Spurious inputs: mem_ready=1 in IDLE/DECODE/HALT and start pulses while busy → no state change and no strobes.
